// File: rtl/ui_io_pkg.sv
// ui_io_pkg: shared seven-segment patterns and saturation bound for the UI helpers
package ui_io_pkg;

    // Patterns are {g,f,e,d,c,b,a}, active-low (0 = lit)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGITS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam int U8_MAX = 255;

endpackage

// File: rtl/key_press_pulse.sv
// key_press_pulse: synchronizes one active-low key and emits a one-cycle pulse per press
module key_press_pulse (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic pressed
);

    // meta/sync form the synchronizer; cur is the registered synchronized level, prev its last value
    logic meta, sync, cur, prev;

    // All level flops rest at 1 (released) so a key held through reset still produces one pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            cur     <= 1'b1;
            prev    <= 1'b1;
            pressed <= 1'b0;
        end else begin
            meta    <= button;
            sync    <= meta;
            cur     <= sync;
            prev    <= cur;
            pressed <= prev & ~cur;
        end
    end

endmodule

// File: rtl/ui_io_helpers.sv
// ui_io_helpers: hex decoder, key press detectors and 8-bit saturator for the kernel/filter UI
module ui_io_helpers
    import ui_io_pkg::*;
#(
    parameter int PRECISION   = 16,
    parameter int NUM_BUTTONS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             hex_bin,
    output logic [6:0]             hex_seg,
    input  logic [NUM_BUTTONS-1:0] button,
    output logic [NUM_BUTTONS-1:0] pressed,
    input  logic [PRECISION-1:0]   round_in,
    output logic [7:0]             round_out
);

    // Nibble to segment pattern lookup
    always_comb begin
        hex_seg = SEG_DIGITS[hex_bin];
    end

    // Negative values clamp to 0 via the sign bit; non-negative values above 255 clamp to 255
    always_comb begin
        round_out = round_in[PRECISION-1]                ? 8'd0 :
                    (round_in > PRECISION'(U8_MAX))      ? 8'(U8_MAX) :
                                                           round_in[7:0];
    end

    genvar i;
    generate
        for (i = 0; i < NUM_BUTTONS; i++) begin : g_key
            key_press_pulse u_kpp (
                .clk     (clk),
                .reset   (reset),
                .button  (button[i]),
                .pressed (pressed[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ui_io_helpers.sv
// tb_ui_io_helpers: directed self-checking bench for ui_io_helpers
module tb_ui_io_helpers;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hex_bin;
    logic [6:0]  hex_seg;
    logic [1:0]  button;
    logic [1:0]  pressed;
    logic [15:0] round_in;
    logic [7:0]  round_out;

    int checks = 0;
    int failures = 0;

    ui_io_helpers #(.PRECISION(16), .NUM_BUTTONS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .hex_bin   (hex_bin),
        .hex_seg   (hex_seg),
        .button    (button),
        .pressed   (pressed),
        .round_in  (round_in),
        .round_out (round_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        button = 2'b11;
        hex_bin = 4'h0;
        round_in = 16'd0;
        repeat (3) tick();
        checks++;
        if (pressed !== 2'b00) begin
            failures++;
            $display("FAIL reset_pressed got=%b want=00", pressed);
        end
        reset = 1'b1;
        repeat (4) tick();
        checks++;
        if (pressed !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle got=%b want=00", pressed);
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp_tab [16];
        exp_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int n = 0; n < 16; n++) begin
            hex_bin = 4'(n);
            #1;
            checks++;
            if (hex_seg !== exp_tab[n]) begin
                failures++;
                $display("FAIL hex_%0h got=%b want=%b", n, hex_seg, exp_tab[n]);
            end
        end
    endtask

    task automatic test_single_press();
        button = 2'b10;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 2) button = 2'b11;
            checks++;
            if (pressed !== ((c == 3) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL single_press cyc=%0d got=%b want=%b", c, pressed, (c == 3) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_hold_and_repress();
        int pulses = 0;
        button = 2'b01;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (pressed[1]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL hold_pulses got=%0d want=1", pulses);
        end
        button = 2'b11;
        repeat (2) tick();
        button = 2'b01;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (pressed[1]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL repress_pulses got=%0d want=1", pulses);
        end
        button = 2'b11;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_pulse();
        int pulses = 0;
        button = 2'b10;
        repeat (4) tick();
        checks++;
        if (pressed !== 2'b01) begin
            failures++;
            $display("FAIL mid_pulse_pre got=%b want=01", pressed);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pressed !== 2'b00) begin
            failures++;
            $display("FAIL mid_pulse_async_clear got=%b want=00", pressed);
        end
        button = 2'b11;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (pressed != 2'b00) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL post_reset_released got=%0d pulses want=0", pulses);
        end
    endtask

    task automatic test_held_through_reset();
        reset = 1'b0;
        button = 2'b10;
        repeat (2) tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (pressed !== ((c == 3) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL held_reset cyc=%0d got=%b want=%b", c, pressed, (c == 3) ? 2'b01 : 2'b00);
            end
        end
        button = 2'b11;
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        button = 2'b00;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 1) button = 2'b11;
            checks++;
            if (pressed !== ((c == 3) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL both_keys cyc=%0d got=%b want=%b", c, pressed, (c == 3) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] ins  [9];
        logic [7:0]  outs [9];
        ins  = '{16'hFFFF, 16'h0000, 16'd128, 16'd255, 16'd256, 16'h7FFF, 16'h8000, 16'd77, 16'hFF00};
        outs = '{8'd0,     8'd0,     8'd128,  8'd255,  8'd255,  8'd255,   8'd0,     8'd77,  8'd0};
        for (int n = 0; n < 9; n++) begin
            round_in = ins[n];
            #1;
            checks++;
            if (round_out !== outs[n]) begin
                failures++;
                $display("FAIL sat in=%h got=%0d want=%0d", ins[n], round_out, outs[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_single_press();
        test_hold_and_repress();
        test_reset_mid_pulse();
        test_held_through_reset();
        test_back_to_back();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ui_io_helpers.md
Name: ui_io_helpers

Overview:
Shared user-I/O and arithmetic helper block for the filter datapath and the custom-kernel editor. It provides three functions:
- a 4-bit to seven-segment hex decoder;
- per-key press detectors that turn each raw active-low KEY into a single-cycle pulse;
- a signed-to-8-bit saturating converter for convolution results.
It sits between the board I/O (KEY, HEX) and the kernel/filter logic.

Parameters:
PRECISION, 16, width of the signed convolution value fed to the saturator.
NUM_BUTTONS, 2, number of independent key press detectors.

Ports:
clk  input  1  VGA pixel clock (25 MHz); all registers use its rising edge.
reset  input  1  asynchronous, active-low reset.
hex_bin  input  4  unsigned nibble to display.
hex_seg  output  7  segment pattern {g,f,e,d,c,b,a}; active-low (0 = lit).
button  input  NUM_BUTTONS  raw KEY levels, active-low (0 = pressed); asynchronous to clk.
pressed  output  NUM_BUTTONS  one-cycle press pulse per key.
round_in  input  PRECISION  signed two's-complement value.
round_out  output  8  saturated unsigned result.

Behaviour:
Hex decoder (combinational, no latency):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Narrower callers zero-extend into hex_bin.
- Package constants: blank = 1111111, minus sign = 0111111 (only g lit).

Press detector (per bit, independent of the other bits):
- Two-flop synchronizer, then one "previous" flop.
- pressed[i] is registered and asserts when the synchronized level is 0 and the previous level is 1, i.e. on a falling edge.
- A key first sampled low at rising edge k drives pressed[i] high from edge k+3 to edge k+4: exactly one cycle, regardless of how long the key is held.
- No further pulse until the key has been synchronously seen high at least once and then goes low again.
- A low pulse shorter than one clock may be missed; no debounce filtering.
- Reset (async, while reset=0): synchronizer and previous flops load 1 (released); pressed=0.
- A key held low across reset deassertion yields one pulse after the normal 3-cycle latency.
- Reset asserted mid-pulse clears pressed immediately.

Saturator (combinational, no latency):
- round_in < 0 gives 0.
- round_in > 255 gives 255.
- Otherwise round_out = round_in[7:0].
- Compare signed at full PRECISION width; no truncation before comparison. Boundary values: -1 gives 0, 0 gives 0, 255 gives 255, 256 gives 255, most-negative gives 0, most-positive gives 255.
- Division or shifting (e.g. >>>4 for blur) is done by the caller before the input.

Outputs at reset:
- pressed = 0.
- hex_seg and round_out follow their inputs combinationally, unaffected by reset.

Decomposition:
- Package ui_io_pkg: SEG_BLANK, SEG_MINUS, the 16-entry digit table as a constant array, and a saturation bound constant (U8_MAX = 255).
- One sub-module, key_press_pulse (single-bit synchronizer plus edge detector), generated NUM_BUTTONS times.
- Decoder and saturator stay inline as always_comb logic.

Test Plan:
1. Sweep hex_bin 0..F → hex_seg matches the table (0 → 1000000, 8 → 0000000, F → 0001110).
2. Reset low then high, button=2'b11; drive button[0]=0 for 3 cycles then 1 → pressed[0] high exactly one cycle, 3 edges after first low sample; pressed[1] stays 0 throughout.
3. Hold button[1]=0 for 100 cycles → exactly one pulse; release for 2 cycles and press again → second pulse.
4. Assert reset while pressed[0]=1 → pressed drops to 0 at once without waiting for a clock edge; after release with button high, no pulse.
5. round_in = -1, 0, 128, 255, 256, 0x7FFF, 0x8000 → round_out = 0, 0, 128, 255, 255, 255, 0.
6. Keys 0 and 1 pressed on the same cycle → both pressed bits pulse on the same cycle.
